alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, ALU operand/result width.
REQ-002 SHALL have parameter CTRL_W, default 4, ALU control code width.
REQ-003 SHALL have parameter ALU_LAT, default 1, cycles (>=1) from operand drive to ALU result valid.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req_valid / req_ready  input / output  2 / 2  per-requester handshake, bit i = requester i.
REQ-007 SHALL have ports req_op1, req_op2  input  2*DATA_W each  operands, requester i in slice [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ctrl  input  2*CTRL_W  ALU control code per requester.
REQ-009 SHALL have ports rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-010 SHALL have ports rsp_id, rsp_result, rsp_zero  output  1, DATA_W, 1  owner, result and zero flag.
REQ-011 SHALL have ports ALU_operand_1, ALU_operand_2, ALU_ctrl_input  output  DATA_W, DATA_W, CTRL_W  drive to shared ALU.
REQ-012 SHALL have ports ALU_result, Zero  input  DATA_W, 1  returned from shared ALU.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, one operation in flight.
REQ-014 IDLE: req_ready[i] SHALL be 1 only for the granted requester, only when its req_valid=1; combinational from state, req_valid and pointer.
REQ-015 Acceptance (req_valid[i] & req_ready[i]) SHALL latch op1/op2/ctrl/id and move to EXEC next cycle.
REQ-016 Both valid in same cycle: grant SHALL go to requester named by the round-robin pointer; only one accepted.
REQ-017 After a grant to i, pointer SHALL point to 1-i; a lone requester SHALL still win every IDLE cycle.
REQ-018 EXEC: ALU_* outputs SHALL carry latched values for exactly ALU_LAT cycles; in the last cycle ALU_result and Zero SHALL be captured; then RESP.
REQ-019 RESP: rsp_valid=1 with stable rsp_id/result/zero until rsp_ready=1; rsp_valid & rsp_ready SHALL return to IDLE next cycle.
REQ-020 Latency: accept at cycle t -> rsp_valid at t+ALU_LAT+1; min issue interval ALU_LAT+2 cycles.
REQ-021 ALU_* outputs SHALL hold last latched values outside EXEC; req_ready SHALL be 0 in EXEC and RESP.
REQ-022 Requester changing operands after acceptance SHALL NOT affect the in-flight operation.

Reset
REQ-023 reset SHALL asynchronously force IDLE, pointer=0, rsp_valid=0, rsp_id/rsp_result/rsp_zero=0, ALU_* outputs=0.
REQ-024 Reset in EXEC or RESP SHALL drop the operation; no response issued after release.
REQ-025 First cycle after release SHALL be able to accept a request.

Configuration
REQ-026 With ALU_ARB_PERF_EN defined: ports perf_grant0, perf_grant1 (output, 16 each) SHALL count accepted grants per requester, saturating at 16'hFFFF, cleared by reset.
REQ-027 Without ALU_ARB_PERF_EN: perf ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package alu_arb_pkg SHALL hold the FSM state encoding (IDLE/EXEC/RESP) and default DATA_W/CTRL_W constants.
REQ-029 Round-robin selection SHALL be a sub-module alu_arb_rr (inputs req_valid, pointer; output one-hot grant).

Verification
REQ-030 Req0 only, op1=15, op2=10, ctrl=4'b0110, bench ALU model ctrl 0110=add, ALU_LAT=1 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_result=25, rsp_zero=0.
REQ-031 Both valid after reset (pointer=0) -> req0 served first, req1 next; rsp_id sequence 0,1.
REQ-032 Req0 continuously valid, req1 idle -> req0 granted back-to-back every ALU_LAT+2 cycles.
REQ-033 rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout; accepted only after rsp_ready=1.
REQ-034 reset asserted mid-EXEC -> outputs zero immediately, no rsp_valid after release; next request served normally.
REQ-035 With ALU_ARB_PERF_EN: 3 grants req0, 2 grants req1 -> perf_grant0=3, perf_grant1=2; op1=op2=5 with ctrl 4'b0110 mapped to subtract -> rsp_zero=1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arb_pkg : shared types and default widths for the ALU arbiter    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package alu_arb_pkg;

  localparam int c_DATA_W_DEF = 8;
  localparam int c_CTRL_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage : alu_arb_pkg
`default_nettype wire

// File: rtl/alu_arb_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arb_rr : two-way round-robin selector, one-hot grant             |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module alu_arb_rr (
  input  logic [1:0] req_valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  // Pointer only matters on contention; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) begin
      grant = pointer ? 2'b10 : 2'b01;
    end else begin
      grant = req_valid;
    end
  end

endmodule : alu_arb_rr
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arbiter : shares one ALU between two requesters, one op in flight|
// | Option      : ALU_ARB_PERF_EN adds per-requester grant counters      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W_DEF,
  parameter int CTRL_W  = c_CTRL_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_op1,
  input  logic [2*DATA_W-1:0] req_op2,
  input  logic [2*CTRL_W-1:0] req_ctrl,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_result,
  output logic                rsp_zero,
  output logic [DATA_W-1:0]   ALU_operand_1,
  output logic [DATA_W-1:0]   ALU_operand_2,
  output logic [CTRL_W-1:0]   ALU_ctrl_input,
  input  logic [DATA_W-1:0]   ALU_result,
  input  logic                Zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]         perf_grant0,
  output logic [15:0]         perf_grant1
`endif
);

  localparam int c_CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t             r_state;
  state_t             w_next;
  logic               r_ptr;
  logic               r_id;
  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         w_grant;
  logic               w_accept;
  logic               w_gnt_id;
  logic               w_last;

  alu_arb_rr u_rr (
    .req_valid (req_valid),
    .pointer   (r_ptr),
    .grant     (w_grant)
  );

  assign req_ready = (r_state == IDLE) ? w_grant : 2'b00;
  assign w_accept  = |(req_valid & req_ready);
  assign w_gnt_id  = w_grant[1];
  assign w_last    = (r_cnt == c_CNT_W'(ALU_LAT - 1));
  assign rsp_valid = (r_state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_next = EXEC;
      EXEC:    if (w_last)    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ALU drive registers double as the operand latch, so they hold between ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr          <= 1'b0;
      r_id           <= 1'b0;
      r_cnt          <= '0;
      ALU_operand_1  <= '0;
      ALU_operand_2  <= '0;
      ALU_ctrl_input <= '0;
      rsp_id         <= 1'b0;
      rsp_result     <= '0;
      rsp_zero       <= 1'b0;
    end else begin
      if (w_accept) begin
        ALU_operand_1  <= w_gnt_id ? req_op1[DATA_W +: DATA_W] : req_op1[0 +: DATA_W];
        ALU_operand_2  <= w_gnt_id ? req_op2[DATA_W +: DATA_W] : req_op2[0 +: DATA_W];
        ALU_ctrl_input <= w_gnt_id ? req_ctrl[CTRL_W +: CTRL_W] : req_ctrl[0 +: CTRL_W];
        r_id           <= w_gnt_id;
        r_ptr          <= ~w_gnt_id;
        r_cnt          <= '0;
      end
      if (r_state == EXEC) begin
        if (w_last) begin
          rsp_id     <= r_id;
          rsp_result <= ALU_result;
          rsp_zero   <= Zero;
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_grant0 <= 16'h0000;
      perf_grant1 <= 16'h0000;
    end else if (w_accept) begin
      if (!w_gnt_id && (perf_grant0 != 16'hFFFF)) perf_grant0 <= perf_grant0 + 16'd1;
      if ( w_gnt_id && (perf_grant1 != 16'hFFFF)) perf_grant1 <= perf_grant1 + 16'd1;
    end
  end
`endif

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_arbiter : directed self-checking bench for alu_arbiter        |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_alu_arbiter;

  localparam int c_LAT = 1;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_op1;
  logic [15:0] req_op2;
  logic [7:0]  req_ctrl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_result;
  logic        rsp_zero;
  logic [7:0]  ALU_operand_1;
  logic [7:0]  ALU_operand_2;
  logic [3:0]  ALU_ctrl_input;
  logic [7:0]  ALU_result;
  logic        Zero;
`ifdef ALU_ARB_PERF_EN
  logic [15:0] perf_grant0;
  logic [15:0] perf_grant1;
`endif

  logic sub_mode;
  int   n_total;
  int   n_bad;
  int   cyc;
  int   t_acc [3];

  alu_arbiter #(.DATA_W(8), .CTRL_W(4), .ALU_LAT(c_LAT)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op1        (req_op1),
    .req_op2        (req_op2),
    .req_ctrl       (req_ctrl),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_result     (rsp_result),
    .rsp_zero       (rsp_zero),
    .ALU_operand_1  (ALU_operand_1),
    .ALU_operand_2  (ALU_operand_2),
    .ALU_ctrl_input (ALU_ctrl_input),
    .ALU_result     (ALU_result),
    .Zero           (Zero)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant0    (perf_grant0),
    .perf_grant1    (perf_grant1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU model; 0110 is add by default, subtract when sub_mode is set.
  always_comb begin
    case (ALU_ctrl_input)
      4'b0110: ALU_result = sub_mode ? (ALU_operand_1 - ALU_operand_2) : (ALU_operand_1 + ALU_operand_2);
      4'b0000: ALU_result = ALU_operand_1 & ALU_operand_2;
      4'b0001: ALU_result = ALU_operand_1 | ALU_operand_2;
      default: ALU_result = ALU_operand_1 ^ ALU_operand_2;
    endcase
  end
  assign Zero = (ALU_result == 8'h00);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    req_op1[id*8 +: 8]  = a;
    req_op2[id*8 +: 8]  = b;
    req_ctrl[id*4 +: 4] = c;
  endtask

  // Returns on the negedge after acceptance (state is EXEC there).
  task automatic wait_accept(input int id);
    int         n;
    logic [1:0] exp;
    n   = 0;
    exp = (id == 1) ? 2'b10 : 2'b01;
    #1;
    while (!(req_valid[id] && req_ready[id]) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("grant", 32'(req_ready), 32'(exp));
    @(negedge clk);
  endtask

  // Called from the negedge following acceptance; expects rsp_valid after c_LAT cycles.
  task automatic wait_rsp(input string tag, input logic id, input logic [7:0] res, input logic z);
    int n;
    n = 0;
    #1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_lat"},  32'(n), 32'(c_LAT));
    check({tag, "_id"},   32'(rsp_id), 32'(id));
    check({tag, "_res"},  32'(rsp_result), 32'(res));
    check({tag, "_zero"}, 32'(rsp_zero), 32'(z));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    cyc       = 0;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_op1   = '0;
    req_op2   = '0;
    req_ctrl  = '0;
    rsp_ready = 1'b1;
    sub_mode  = 1'b0;

    // Reset state
    @(negedge clk); #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_res",   32'(rsp_result), 32'(0));
    check("rst_alu_op1",   32'(ALU_operand_1), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    reset = 1'b0;

    // Basic add, request presented in the first cycle after release
    set_req(0, 8'd15, 8'd10, 4'b0110);
    req_valid = 2'b01;
    wait_accept(0);
    req_valid = 2'b00;
    req_op1[7:0] = 8'd99;
    #1;
    check("exec_op1",   32'(ALU_operand_1), 32'(15));
    check("exec_ctrl",  32'(ALU_ctrl_input), 32'(4'b0110));
    check("exec_ready", 32'(req_ready), 32'(0));
    wait_rsp("add", 1'b0, 8'd25, 1'b0);
    @(negedge clk); #1;
    check("idle_rsp_valid", 32'(rsp_valid), 32'(0));
    check("hold_op2",       32'(ALU_operand_2), 32'(10));

    // Contention after reset: requester 0 first, then 1
    do_reset();
    set_req(0, 8'd3, 8'd4, 4'b0110);
    set_req(1, 8'd20, 8'd30, 4'b0110);
    req_valid = 2'b11;
    #1;
    check("rr_first", 32'(req_ready), 32'(2'b01));
    wait_accept(0);
    check("rr_latched", 32'(ALU_operand_1), 32'(3));
    wait_rsp("rr0", 1'b0, 8'd7, 1'b0);
    @(negedge clk); #1;
    check("rr_second", 32'(req_ready), 32'(2'b10));
    wait_accept(1);
    req_valid = 2'b00;
    wait_rsp("rr1", 1'b1, 8'd50, 1'b0);
    @(negedge clk);

    // Lone requester served back-to-back
    set_req(0, 8'd1, 8'd1, 4'b0110);
    req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      wait_accept(0);
      t_acc[k] = cyc;
    end
    req_valid = 2'b00;
    check("b2b_int0", 32'(t_acc[1] - t_acc[0]), 32'(c_LAT + 2));
    check("b2b_int1", 32'(t_acc[2] - t_acc[1]), 32'(c_LAT + 2));
    wait_rsp("b2b", 1'b0, 8'd2, 1'b0);
    @(negedge clk);

    // Response back-pressure
    rsp_ready = 1'b0;
    set_req(1, 8'd100, 8'd27, 4'b0110);
    req_valid = 2'b10;
    wait_accept(1);
    req_valid = 2'b00;
    wait_rsp("bp", 1'b1, 8'd127, 1'b0);
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("bp_valid", 32'(rsp_valid), 32'(1));
      check("bp_res",   32'(rsp_result), 32'(127));
      check("bp_ready", 32'(req_ready), 32'(0));
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    req_valid = 2'b00;
    check("bp_release", 32'(rsp_valid), 32'(0));

    // Reset in the middle of EXEC
    set_req(0, 8'd9, 8'd9, 4'b0110);
    req_valid = 2'b01;
    wait_accept(0);
    req_valid = 2'b00;
    #1;
    check("mid_exec_op1", 32'(ALU_operand_1), 32'(9));
    reset = 1'b1;
    #1;
    check("arst_op1", 32'(ALU_operand_1), 32'(0));
    check("arst_res", 32'(rsp_result), 32'(0));
    check("arst_id",  32'(rsp_id), 32'(0));
    @(negedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("arst_no_rsp", 32'(rsp_valid), 32'(0));
    end
    set_req(1, 8'd40, 8'd2, 4'b0110);
    req_valid = 2'b10;
    wait_accept(1);
    req_valid = 2'b00;
    wait_rsp("post_rst", 1'b1, 8'd42, 1'b0);
    @(negedge clk);

    // Subtract mapping: zero flag, then nonzero, then AND
    sub_mode = 1'b1;
    set_req(0, 8'd5, 8'd5, 4'b0110);
    req_valid = 2'b01;
    wait_accept(0);
    req_valid = 2'b00;
    wait_rsp("sub_zero", 1'b0, 8'd0, 1'b1);
    set_req(1, 8'd9, 8'd4, 4'b0110);
    req_valid = 2'b10;
    wait_accept(1);
    req_valid = 2'b00;
    wait_rsp("sub_nz", 1'b1, 8'd5, 1'b0);
    set_req(0, 8'hF0, 8'h3C, 4'b0000);
    req_valid = 2'b01;
    wait_accept(0);
    req_valid = 2'b00;
    wait_rsp("and", 1'b0, 8'h30, 1'b0);
    @(negedge clk);

    // Alternating grants under continuous contention: 0,1,0,1,0
    do_reset();
    set_req(0, 8'd1, 8'd2, 4'b0001);
    set_req(1, 8'd4, 8'd8, 4'b0001);
    req_valid = 2'b11;
    wait_accept(0);
    wait_accept(1);
    wait_accept(0);
    wait_accept(1);
    wait_accept(0);
    req_valid = 2'b00;
    wait_rsp("alt_last", 1'b0, 8'd3, 1'b0);
    @(negedge clk); #1;
`ifdef ALU_ARB_PERF_EN
    check("perf_grant0", 32'(perf_grant0), 32'(3));
    check("perf_grant1", 32'(perf_grant1), 32'(2));
    do_reset();
    #1;
    check("perf_clr0", 32'(perf_grant0), 32'(0));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_alu_arbiter
`default_nettype wire
